// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if -- operand/result handshake bundle for pipe_addsub.
// The slave modport is the adder side; the master modport is the side that
// supplies operands and consumes results.
interface pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_ovf;
  logic             o_zero;
  logic             o_neg;

  modport master (
    output i_valid, i_a, i_b, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_ovf, o_zero, o_neg
  );

  modport slave (
    input  i_valid, i_a, i_b, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_ovf, o_zero, o_neg
  );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub -- pipelined adder/subtractor with valid/ready handshake.
// The operands are cut into STAGES equal segments, LSB first; stage k adds
// segment k with a Kogge-Stone carry-lookahead and hands its carry to stage
// k+1 through a register. The accumulator word rotates right by one segment
// per stage: unprocessed A segments sit at the bottom, finished sum segments
// fill in from the top, so after the last stage the sum is fully aligned.
// Unprocessed B segments travel in a register that shrinks by one segment
// per stage.
// Optional feature macro: PIPE_ADDSUB_FLAGS_EN enables the registered
// o_ovf/o_zero/o_neg flags; without it those outputs are tied low.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic          i_clk,
  input logic          i_rst_n,
  pipe_addsub_if.slave bus
);

  localparam int SEG = WIDTH / STAGES;

  // Carries c[0..SEG] for one segment: c[0] = cin, c[SEG] = carry out.
  function automatic logic [SEG:0] cla_carries(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           cin
  );
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    g = a & b;
    p = a ^ b;
    // Parallel prefix: after the loop g[i]/p[i] cover bits [i:0]
    for (int d = 1; d < SEG; d = d * 2) begin
      for (int i = SEG - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & cin);
    end
    return c;
  endfunction

  logic en_s;
  logic last_valid_s;

  // The whole pipe advances together; it only stops when a result is stuck
  assign en_s        = ~last_valid_s | bus.i_ready;
  assign bus.o_ready = en_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int BIN = WIDTH - k * SEG;

    logic [WIDTH-1:0] acc_in_s;
    logic [BIN-1:0]   b_in_s;
    logic             cin_s;
    logic             vin_s;
    logic [SEG:0]     c_s;
    logic [SEG-1:0]   seg_sum_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic             valid_r;
    logic             carry_r;
    logic [WIDTH-1:0] acc_r;

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + 1
      assign acc_in_s = bus.i_a;
      assign b_in_s   = bus.i_b ^ {WIDTH{bus.i_sub}};
      assign cin_s    = bus.i_sub;
      assign vin_s    = bus.i_valid;
    end else begin : g_src
      assign acc_in_s = g_stg[k-1].acc_r;
      assign b_in_s   = g_stg[k-1].g_bfwd.b_r;
      assign cin_s    = g_stg[k-1].carry_r;
      assign vin_s    = g_stg[k-1].valid_r;
    end

    assign c_s       = cla_carries(acc_in_s[SEG-1:0], b_in_s[SEG-1:0], cin_s);
    assign seg_sum_s = acc_in_s[SEG-1:0] ^ b_in_s[SEG-1:0] ^ c_s[SEG-1:0];

    if (SEG == WIDTH) begin : g_rot
      assign acc_nxt_s = seg_sum_s;
    end else begin : g_rot
      assign acc_nxt_s = {seg_sum_s, acc_in_s[WIDTH-1:SEG]};
    end

    if (k < STAGES - 1) begin : g_bfwd
      logic [BIN-SEG-1:0] b_r;

      // Carry the still-unprocessed upper B segments along with this stage
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          b_r <= '0;
        end else if (en_s) begin
          b_r <= b_in_s[BIN-1:SEG];
        end else begin
          b_r <= b_r;
        end
      end
    end

    // Stage register: advance with the pipe, hold on stall, valid clears on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        acc_r   <= '0;
      end else if (en_s) begin
        valid_r <= vin_s;
        carry_r <= c_s[SEG];
        acc_r   <= acc_nxt_s;
      end else begin
        valid_r <= valid_r;
        carry_r <= carry_r;
        acc_r   <= acc_r;
      end
    end
  end

  assign last_valid_s = g_stg[STAGES-1].valid_r;
  assign bus.o_valid  = last_valid_s;
  assign bus.o_sum    = g_stg[STAGES-1].acc_r;
  assign bus.o_carry  = g_stg[STAGES-1].carry_r;

`ifdef PIPE_ADDSUB_FLAGS_EN
  logic             fin_cout_s;
  logic             fin_cmsb_s;
  logic [WIDTH-1:0] fin_sum_s;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;

  assign fin_cout_s = g_stg[STAGES-1].c_s[SEG];
  assign fin_cmsb_s = g_stg[STAGES-1].c_s[SEG-1];
  assign fin_sum_s  = g_stg[STAGES-1].acc_nxt_s;

  // Result flags, captured alongside the final stage so they stay aligned
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
    end else if (en_s) begin
      ovf_r  <= fin_cout_s ^ fin_cmsb_s;
      zero_r <= (fin_sum_s == '0);
      neg_r  <= fin_sum_s[WIDTH-1];
    end else begin
      ovf_r  <= ovf_r;
      zero_r <= zero_r;
      neg_r  <= neg_r;
    end
  end

  assign bus.o_ovf  = ovf_r;
  assign bus.o_zero = zero_r;
  assign bus.o_neg  = neg_r;
`else
  assign bus.o_ovf  = 1'b0;
  assign bus.o_zero = 1'b0;
  assign bus.o_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub -- scoreboard bench for pipe_addsub.
// Accepted operand sets push an arithmetic reference result into a queue;
// an independent monitor compares every presented result against the queue
// head. Honors PIPE_ADDSUB_FLAGS_EN for the flag expectations.
module tb_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
);

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
    int               cyc;
    int               stalls;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rnd_done = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  exp_t exp_q[$];
  logic [WIDTH-1:0] mins;
  logic [WIDTH-1:0] maxs;

  pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic and sign rules
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
    exp_t e;
    logic [WIDTH:0] full;
    if (sub) begin
      e.sum   = a - b;
      e.carry = (a >= b);
      e.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full    = {1'b0, a} + {1'b0, b};
      e.sum   = full[WIDTH-1:0];
      e.carry = full[WIDTH];
      e.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end
    e.zero = (e.sum == '0);
    e.neg  = e.sum[WIDTH-1];
`ifndef PIPE_ADDSUB_FLAGS_EN
    e.ovf  = 1'b0;
    e.zero = 1'b0;
    e.neg  = 1'b0;
`endif
    e.cyc    = 0;
    e.stalls = 0;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_operand();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return mins;
      3:       return maxs;
      4:       return WIDTH'(1);
      default: return r[WIDTH-1:0];
    endcase
  endfunction

  // Producer: every accepted operand set queues its expected result
  always @(negedge clk) begin
    if (rst_n && bus.i_valid && bus.o_ready) begin
      exp_t e;
      e        = model(bus.i_a, bus.i_b, bus.i_sub);
      e.cyc    = cyc;
      e.stalls = stall_cnt;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every presented result with the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.o_valid) begin
        check("ready_idle", 64'(bus.o_ready), 64'd1);
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got o_valid=1 expected no result (t=%0t)", $time);
      end else begin
        check("sum",   64'(bus.o_sum),   64'(exp_q[0].sum));
        check("carry", 64'(bus.o_carry), 64'(exp_q[0].carry));
        check("ovf",   64'(bus.o_ovf),   64'(exp_q[0].ovf));
        check("zero",  64'(bus.o_zero),  64'(exp_q[0].zero));
        check("neg",   64'(bus.o_neg),   64'(exp_q[0].neg));
        if (bus.i_ready) begin
          if (stall_cnt == exp_q[0].stalls) begin
            check("latency", 64'(cyc - exp_q[0].cyc), 64'(STAGES));
          end
          void'(exp_q.pop_front());
        end else begin
          check("ready_stall", 64'(bus.o_ready), 64'd0);
          stall_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    logic acc;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_sub   = sub;
    bus.i_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got o_ready=0 for 100 cycles expected acceptance");
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    check({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    check({tag, "_sum"},   64'(bus.o_sum),   64'd0);
    check({tag, "_carry"}, 64'(bus.o_carry), 64'd0);
    check({tag, "_ovf"},   64'(bus.o_ovf),   64'd0);
    check({tag, "_zero"},  64'(bus.o_zero),  64'd0);
    check({tag, "_neg"},   64'(bus.o_neg),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mins = '0;
    mins[WIDTH-1] = 1'b1;
    maxs = ~mins;
    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_sub   = 1'b0;
    bus.i_ready = 1'b1;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner operations
    send('1, WIDTH'(1), 1'b0);
    send(WIDTH'(5), WIDTH'(7), 1'b1);
    send(WIDTH'(7), WIDTH'(5), 1'b1);
    send(maxs, WIDTH'(1), 1'b0);
    send(mins, WIDTH'(1), 1'b1);
    send('0, '0, 1'b0);
    send('0, '0, 1'b1);
    idle(STAGES + 2);

    // Back-to-back stream of 8 with a 3-cycle downstream stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_operand(), rnd_operand(), i[0]);
      end
      begin
        repeat (STAGES + 3) @(posedge clk);
        #1 bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.i_ready = 1'b1;
      end
    join
    idle(STAGES + 2);

    // Reset between edges with two operations in flight
    send(WIDTH'(3), WIDTH'(4), 1'b0);
    send(WIDTH'(9), WIDTH'(2), 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    bus.i_valid = 1'b1;
    bus.i_a     = '1;
    bus.i_b     = '1;
    repeat (2) @(posedge clk);
    #1 check("rst_hold_valid", 64'(bus.o_valid), 64'd0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(maxs, maxs, 1'b0);
    idle(STAGES + 2);

    // Randomized traffic with random gaps and random downstream backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) idle(1);
          send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.i_ready = ($urandom_range(0, 3) != 0);
        end
        bus.i_ready = 1'b1;
      end
    join

    // Drain remaining results
    bus.i_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal 8..64, multiple of STAGES.
REQ-002 Parameter: STAGES, default 2, pipeline depth = number of carry-chain segments; legal 1..4.
REQ-003 Port: i_clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: i_valid  input  1  operand set present.
REQ-006 Port: o_ready  output  1  block accepts operands this cycle.
REQ-007 Port: i_a, i_b  input  WIDTH each  operands.
REQ-008 Port: i_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 Port: o_valid  output  1  result present.
REQ-010 Port: i_ready  input  1  downstream accepts result.
REQ-011 Port: o_sum  output  WIDTH  result.
REQ-012 Port: o_carry  output  1  carry out of MSB; for subtraction, 1 = no borrow.
REQ-013 Port: o_ovf, o_zero, o_neg  output  1 each  signed overflow, result==0, result MSB.

Function
REQ-014 Sub mode: B bitwise inverted, carry-in 1. Add mode: carry-in 0. Result is modulo 2^WIDTH.
REQ-015 Operand split into STAGES equal segments, LSB first. Segment k uses carry-lookahead over SEG=WIDTH/STAGES bits in pipeline stage k; its carry-in is the registered carry out of segment k-1.
REQ-016 Not-yet-processed upper operand segments and completed lower sum segments are registered and travel with their stage (skew/deskew); o_sum is always fully aligned.
REQ-017 Each stage holds one valid bit. Global advance enable en = !o_valid | i_ready. o_ready = en.
REQ-018 Transfer in on i_valid & o_ready. Transfer out on o_valid & i_ready.
REQ-019 Latency is exactly STAGES cycles from input transfer to o_valid when never stalled. Throughput is one result per cycle.
REQ-020 When en=0, every stage register, valid bit and output holds. Bubbles do not collapse.
REQ-021 When en=1 and i_valid=0, a bubble enters stage 1. Stage data is don't-care while its valid bit is 0.
REQ-022 o_sum, o_carry and flags are stable while o_valid=1 and i_ready=0.
REQ-023 Simultaneous input transfer and output transfer in one cycle are both legal and lossless.
REQ-024 o_ovf = carry into MSB XOR carry out of MSB, using the effective (possibly inverted) B.
REQ-025 STAGES=1 degenerates to a single registered full-width CLA add/sub with latency 1.

Reset
REQ-026 When i_rst_n=0, all valid bits clear immediately, without waiting for a clock edge.
REQ-027 Reset values: o_valid=0, o_sum=0, o_carry=0, o_ovf=0, o_zero=0, o_neg=0.
REQ-028 o_ready=1 while in reset, because o_valid=0. Inputs are ignored until i_rst_n is high at an i_clk edge.
REQ-029 Reset mid-operation discards all in-flight operations. No partial result ever appears.

Configuration
REQ-030 Macro PIPE_ADDSUB_FLAGS_EN defined: o_ovf, o_zero and o_neg are computed per REQ-013/REQ-024 and registered with the final stage.
REQ-031 Macro PIPE_ADDSUB_FLAGS_EN undefined: o_ovf, o_zero and o_neg are tied 0, and their logic and registers are absent. o_carry and o_sum are unaffected.

Verification
REQ-032 WIDTH=32, STAGES=2, add 0xFFFFFFFF+0x00000001 -> o_valid 2 cycles later, o_sum=0, o_carry=1, o_zero=1, o_ovf=0. Exercises the cross-segment carry.
REQ-033 Sub 0x00000005-0x00000007 -> o_sum=0xFFFFFFFE, o_carry=0, o_neg=1. Sub 7-5 -> o_sum=2, o_carry=1.
REQ-034 Add 0x7FFFFFFF+1 -> o_ovf=1, o_neg=1. Sub 0x80000000-1 -> o_sum=0x7FFFFFFF, o_ovf=1.
REQ-035 Back-to-back stream of 8 operations, with i_ready held 0 for 3 cycles mid-stream -> o_ready=0 during the stall, outputs held, all 8 results in order, none lost or duplicated.
REQ-036 Assert i_rst_n=0 between clock edges with 2 operations in flight -> o_valid drops at once; after release, the first new operation emerges with latency STAGES.
REQ-037 Repeat REQ-032 through REQ-035 for STAGES=1, STAGES=4 and WIDTH=64, with and without PIPE_ADDSUB_FLAGS_EN -> results match a reference model; flags are 0 when the macro is undefined.
